rf_write_sched: RTL and testbench

- Write-port scheduler for the 32x32 register file built from REG32 registers and a 5x32 write decoder.
- Shares the file's single write port between two requesters: A (ALU writeback) and B (load/memory writeback).
- Round-robin arbitration on contention; writes to R0 are discarded.
- After reset, optionally sequences a clear of R1..R31 before accepting traffic.

---
 rtl/rf_write_sched_if.sv | 30 +++
 rtl/rf_write_sched.sv | 92 +++++++++
 tb/tb_rf_write_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rf_write_sched_if.sv
// Write-port bundle for rf_write_sched: two requester handshakes plus the
// registered register-file write port and status outputs.
interface rf_write_sched_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              z_drop;
    logic              init_done;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, z_drop, init_done
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, z_drop, init_done
    );
endinterface

// File: rtl/rf_write_sched.sv
// Shares the register file's single write port between requesters A and B with
// round-robin arbitration, R0 write discard, and an optional post-reset clear.
module rf_write_sched #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_sched_if.slave   bus
);
    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {PRI_A, PRI_B} pri_t;

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    pri_t              pri;
    logic [ADDR_W:0]   cnt;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              z_drop_q;
    logic              init_done_q;
    logic              a_grant;
    logic              b_grant;

    // PRI only matters under contention; reset and INIT suppress both grants.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!rst && state == RUN) begin
            a_grant = bus.a_valid && (!bus.b_valid || pri == PRI_A);
            b_grant = bus.b_valid && (!bus.a_valid || pri == PRI_B);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR_ON_RESET ? INIT : RUN;
            pri         <= PRI_A;
            cnt         <= {{ADDR_W{1'b0}}, 1'b1};
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            z_drop_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt[ADDR_W-1:0];
                    wr_data_q <= '0;
                    z_drop_q  <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    init_done_q <= 1'b1;
                    if (a_grant) begin
                        wr_addr_q <= bus.a_addr;
                        wr_data_q <= bus.a_data;
                        wr_en_q   <= (bus.a_addr != '0);
                        z_drop_q  <= (bus.a_addr == '0);
                        pri       <= PRI_B;
                    end else if (b_grant) begin
                        wr_addr_q <= bus.b_addr;
                        wr_data_q <= bus.b_data;
                        wr_en_q   <= (bus.b_addr != '0);
                        z_drop_q  <= (bus.b_addr == '0);
                        pri       <= PRI_A;
                    end else begin
                        wr_en_q  <= 1'b0;
                        z_drop_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.a_ready   = a_grant;
    assign bus.b_ready   = b_grant;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.z_drop    = z_drop_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: one instance with the post-reset clear
// enabled and one without.
module tb_rf_write_sched;
    logic clk;
    logic rst;
    logic rst0;
    int   compared;
    int   mismatched;

    rf_write_sched_if #(.ADDR_W(5), .DATA_W(32)) bus ();
    rf_write_sched_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();

    rf_write_sched #(.ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rf_write_sched #(.ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_valid;
        logic [4:0]  a_addr;
        logic [31:0] a_data;
        logic        b_valid;
        logic [4:0]  b_addr;
        logic [31:0] b_data;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic        exp_wr_en;
        logic [4:0]  exp_wr_addr;
        logic [31:0] exp_wr_data;
        logic        exp_z_drop;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst  = 1'b1;
        rst0 = 1'b1;
        bus0.a_valid = 1'b0; bus0.a_addr = '0; bus0.a_data = '0;
        bus0.b_valid = 1'b0; bus0.b_addr = '0; bus0.b_data = '0;

        // vector: a_valid a_addr a_data b_valid b_addr b_data | a_rdy b_rdy wr_en wr_addr wr_data z_drop
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd7,  32'h1,        1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 1'b1, 5'd9,  32'h99,       1'b0};
        vecs[4]  = '{1'b1, 5'd3,  32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11111111, 1'b0};
        vecs[5]  = '{1'b1, 5'd3,  32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b0, 1'b1, 1'b1, 5'd4,  32'h22222222, 1'b0};
        vecs[6]  = '{1'b1, 5'd3,  32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b1, 1'b0, 1'b1, 5'd3,  32'h11111111, 1'b0};
        vecs[7]  = '{1'b1, 5'd3,  32'h11111111, 1'b1, 5'd4, 32'h22222222, 1'b0, 1'b1, 1'b1, 5'd4,  32'h22222222, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[10] = '{1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'h12345678, 1'b0};
        vecs[11] = '{1'b1, 5'd1,  32'hA,        1'b1, 5'd2, 32'hB,        1'b0, 1'b1, 1'b1, 5'd2,  32'hB,        1'b0};
        vecs[12] = '{1'b1, 5'd6,  32'hAAAA,     1'b1, 5'd6, 32'hBBBB,     1'b1, 1'b0, 1'b1, 5'd6,  32'hAAAA,     1'b0};
        vecs[13] = '{1'b1, 5'd6,  32'hAAAA,     1'b1, 5'd6, 32'hBBBB,     1'b0, 1'b1, 1'b1, 5'd6,  32'hBBBB,     1'b0};
        vecs[14] = '{1'b1, 5'd0,  32'h5,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h5,        1'b1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h5,        1'b0};

        // Reset with A already waiting, then the 31-cycle clear.
        applyStimulus(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0);
        checkOutput("rst_a_ready", 32'(bus.a_ready), 32'd0);
        stepClock();
        checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        checkOutput("rst_wr_data", bus.wr_data, 32'd0);
        checkOutput("rst_z_drop", 32'(bus.z_drop), 32'd0);
        checkOutput("rst_init_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            #1;
            checkOutput($sformatf("init%0d_a_ready", i), 32'(bus.a_ready), 32'd0);
            stepClock();
            checkOutput($sformatf("init%0d_wr_en", i), 32'(bus.wr_en), 32'd1);
            checkOutput($sformatf("init%0d_wr_addr", i), 32'(bus.wr_addr), 32'(i));
            checkOutput($sformatf("init%0d_wr_data", i), bus.wr_data, 32'd0);
            checkOutput($sformatf("init%0d_init_done", i), 32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
        end
        checkOutput("post_init_a_ready", 32'(bus.a_ready), 32'd1);
        stepClock();
        checkOutput("post_init_wr_en", 32'(bus.wr_en), 32'd1);
        checkOutput("post_init_wr_addr", 32'(bus.wr_addr), 32'd7);
        checkOutput("post_init_wr_data", bus.wr_data, 32'h1);

        // Table of single-cycle RUN vectors.
        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].a_valid, vecs[v].a_addr, vecs[v].a_data,
                          vecs[v].b_valid, vecs[v].b_addr, vecs[v].b_data);
            checkOutput($sformatf("v%0d_a_ready", v), 32'(bus.a_ready), 32'(vecs[v].exp_a_ready));
            checkOutput($sformatf("v%0d_b_ready", v), 32'(bus.b_ready), 32'(vecs[v].exp_b_ready));
            stepClock();
            checkOutput($sformatf("v%0d_wr_en", v), 32'(bus.wr_en), 32'(vecs[v].exp_wr_en));
            checkOutput($sformatf("v%0d_wr_addr", v), 32'(bus.wr_addr), 32'(vecs[v].exp_wr_addr));
            checkOutput($sformatf("v%0d_wr_data", v), bus.wr_data, vecs[v].exp_wr_data);
            checkOutput($sformatf("v%0d_z_drop", v), 32'(bus.z_drop), 32'(vecs[v].exp_z_drop));
        end

        // Reset in the middle of continuous A traffic.
        applyStimulus(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'h0);
        checkOutput("traffic_a_ready", 32'(bus.a_ready), 32'd1);
        stepClock();
        checkOutput("traffic_wr_addr", 32'(bus.wr_addr), 32'd10);
        rst = 1'b1;
        #1;
        checkOutput("midrst_a_ready", 32'(bus.a_ready), 32'd0);
        stepClock();
        checkOutput("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("midrst_init_done", 32'(bus.init_done), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reinit_a_ready", 32'(bus.a_ready), 32'd0);
        stepClock();
        checkOutput("reinit_wr_en", 32'(bus.wr_en), 32'd1);
        checkOutput("reinit_wr_addr1", 32'(bus.wr_addr), 32'd1);
        stepClock();
        checkOutput("reinit_wr_addr2", 32'(bus.wr_addr), 32'd2);
        for (int n = 0; n < 40 && !bus.init_done; n++) stepClock();
        checkOutput("reinit_done", 32'(bus.init_done), 32'd1);
        checkOutput("reinit_last_addr", 32'(bus.wr_addr), 32'd31);
        stepClock();
        checkOutput("reinit_a_wr_addr", 32'(bus.wr_addr), 32'd10);
        checkOutput("reinit_a_wr_data", bus.wr_data, 32'h77);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Instance without clear: B request in the first cycle after release.
        stepClock();
        checkOutput("nc_rst_init_done", 32'(bus0.init_done), 32'd0);
        checkOutput("nc_rst_wr_en", 32'(bus0.wr_en), 32'd0);
        rst0 = 1'b0;
        bus0.b_valid = 1'b1;
        bus0.b_addr  = 5'd12;
        bus0.b_data  = 32'hCAFEF00D;
        #1;
        checkOutput("nc_b_ready", 32'(bus0.b_ready), 32'd1);
        checkOutput("nc_init_done_pre", 32'(bus0.init_done), 32'd0);
        stepClock();
        checkOutput("nc_init_done", 32'(bus0.init_done), 32'd1);
        checkOutput("nc_wr_en", 32'(bus0.wr_en), 32'd1);
        checkOutput("nc_wr_addr", 32'(bus0.wr_addr), 32'd12);
        checkOutput("nc_wr_data", bus0.wr_data, 32'hCAFEF00D);
        bus0.b_valid = 1'b0;
        stepClock();
        checkOutput("nc_idle_wr_en", 32'(bus0.wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
